fifo_reader: RTL and testbench



---
 rtl/fifo_reader_pkg.sv | 14 +
 rtl/fifo_reader_buf.sv | 58 +++++
 rtl/fifo_reader.sv | 82 ++++++++
 tb/tb_fifo_reader.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared types and constants for the FIFO read-side stream adapter.
// Optional build macro FIFO_READER_STATS_EN (used in fifo_reader.sv) sizes its counter with STAT_WIDTH.
package fifo_reader_pkg;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_t;

   localparam int BUF_DEPTH  = 2;
   localparam int STAT_WIDTH = 32;

endpackage

// File: rtl/fifo_reader_buf.sv
// fifo_reader_buf: 2-entry circular output buffer with push/pop, head data and occupancy.
// Not affected by FIFO_READER_STATS_EN.
module fifo_reader_buf
   import fifo_reader_pkg::*;
#(
   parameter int WORD_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push,
   input  logic [WORD_WIDTH-1:0] push_data,
   input  logic                  pop,
   output occ_t                  occ,
   output logic [WORD_WIDTH-1:0] head_data
);

   logic [WORD_WIDTH-1:0] mem [BUF_DEPTH];
   logic                  head;
   logic                  tail;
   occ_t                  occ_next;

   // Occupancy moves only when exactly one of push/pop happens.
   always_comb begin
      occ_next = occ;
      case ({push, pop})
         2'b10:   occ_next = occ_t'(occ + 2'd1);
         2'b01:   occ_next = occ_t'(occ - 2'd1);
         default: occ_next = occ;
      endcase
   end

   // Storage and pointers; reset clears contents so the head reads as zero.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         occ    <= OCC_EMPTY;
         head   <= 1'b0;
         tail   <= 1'b0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else begin
         occ <= occ_next;
         if (push) begin
            mem[tail] <= push_data;
            tail      <= ~tail;
         end
         if (pop) begin
            head <= ~head;
         end
      end
   end

   assign head_data = mem[head];

   // Read issue keeps occ + inflight <= 2, so a landing word never meets a full buffer.
   a_no_push_when_full : assert property (@(posedge clk) disable iff (!reset_n)
      !(push && (occ == OCC_TWO)));

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: turns a 1-cycle-latency FIFO read port into a valid/ready stream,
// prefetching into a 2-entry buffer for full throughput under backpressure.
// Build macro FIFO_READER_STATS_EN adds o_word_count (saturating count of accepted words).
module fifo_reader
   import fifo_reader_pkg::*;
#(
   parameter int WORD_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_en,
   output logic                  o_fifo_r_en,
   input  logic [WORD_WIDTH-1:0] i_fifo_r_data,
   input  logic                  i_fifo_empty,
   output logic                  o_valid,
   output logic [WORD_WIDTH-1:0] o_data,
   input  logic                  i_ready,
   output logic                  o_idle
`ifdef FIFO_READER_STATS_EN
   ,
   output logic [STAT_WIDTH-1:0] o_word_count
`endif
);

   // The buffer is built with 1-bit pointers; any other depth is a configuration error.
   if (BUF_DEPTH != 2) begin : g_bad_depth
      $error("fifo_reader: BUF_DEPTH must be 2");
   end

   logic       inflight;
   logic       pop;
   occ_t       occ;
   logic [1:0] occ_after;

   assign pop = o_valid && i_ready;

   // Slots committed after this edge: held words plus the landing word minus the departing one.
   assign occ_after = 2'(occ) + {1'b0, inflight} - {1'b0, pop};

   // Reset gates the read so no FIFO word is consumed while state is being cleared.
   assign o_fifo_r_en = reset_n && i_en && !i_fifo_empty && (occ_after < 2'd2);

   // A read issued this cycle returns data next cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         inflight <= 1'b0;
      end else begin
         inflight <= o_fifo_r_en;
      end
   end

   fifo_reader_buf #(
      .WORD_WIDTH (WORD_WIDTH)
   ) u_buf (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (inflight),
      .push_data (i_fifo_r_data),
      .pop       (pop),
      .occ       (occ),
      .head_data (o_data)
   );

   assign o_valid = (occ != OCC_EMPTY);
   assign o_idle  = (occ == OCC_EMPTY) && !inflight;

`ifdef FIFO_READER_STATS_EN
   logic [STAT_WIDTH-1:0] word_count;

   // Count accepted words, holding at the maximum value.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         word_count <= '0;
      end else if (pop && (word_count != '1)) begin
         word_count <= word_count + 1'b1;
      end
   end

   assign o_word_count = word_count;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed + random scoreboard bench for fifo_reader, with a behavioural
// 1-cycle-latency FIFO. Covers o_word_count when FIFO_READER_STATS_EN is defined.
module tb_fifo_reader;
   import fifo_reader_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         i_en;
   logic         o_fifo_r_en;
   logic [W-1:0] i_fifo_r_data = '0;
   logic         i_fifo_empty;
   logic         o_valid;
   logic [W-1:0] o_data;
   logic         i_ready;
   logic         o_idle;
`ifdef FIFO_READER_STATS_EN
   logic [STAT_WIDTH-1:0] o_word_count;
`endif

   int           checks = 0;
   int           fails  = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] fmem [4096];
   int           wr_ptr = 0;
   int           rd_ptr = 0;
   int           reads  = 0;
   int           pops   = 0;
   int           viol   = 0;
   int           lost   = 0;

   always #5 clk = ~clk;

   assign i_fifo_empty = (wr_ptr == rd_ptr);

   fifo_reader #(
      .WORD_WIDTH (W)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_en          (i_en),
      .o_fifo_r_en   (o_fifo_r_en),
      .i_fifo_r_data (i_fifo_r_data),
      .i_fifo_empty  (i_fifo_empty),
      .o_valid       (o_valid),
      .o_data        (o_data),
      .i_ready       (i_ready),
      .o_idle        (o_idle)
`ifdef FIFO_READER_STATS_EN
      ,
      .o_word_count  (o_word_count)
`endif
   );

   // Behavioural FIFO read port: registered data one cycle after an accepted read.
   always @(posedge clk) begin
      if (o_fifo_r_en && (wr_ptr != rd_ptr)) begin
         i_fifo_r_data <= fmem[rd_ptr];
         rd_ptr        <= rd_ptr + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [W-1:0] d);
      fmem[wr_ptr] = d;
      wr_ptr++;
      exp_q.push_back(d);
   endtask

   // Per-cycle scoreboard check, run at the falling edge.
   task automatic mon();
      logic [W-1:0] e;
      if (reset_n === 1'b1) begin
         if (o_fifo_r_en === 1'b1) begin
            reads++;
            if (i_fifo_empty) viol++;
         end
         if ((o_valid && i_ready) === 1'b1) begin
            pops++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            chk("stream_word", {24'h0, o_data}, {24'h0, e});
         end
      end
   endtask

   task automatic sample();
      @(negedge clk);
      mon();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      sample();
      tick();
   endtask

   task automatic drain(input int bound);
      int n;
      n = 0;
      forever begin
         sample();
         if (o_idle && i_fifo_empty) begin
            tick();
            return;
         end
         tick();
         n++;
         if (n >= bound) begin
            chk("drain_timeout", {31'h0, o_idle}, 32'h1);
            return;
         end
      end
   endtask

   // Words read from the FIFO but not delivered are dropped by a reset.
   task automatic discard_after_reset();
      int n;
      logic [W-1:0] t;
      n = reads - pops - lost;
      lost += n;
      repeat (n) t = exp_q.pop_front();
   endtask

   initial begin
      int r0;
      int wc;
      int cycles;

      // Reset held with FIFO non-empty
      reset_n = 1'b0;
      i_en    = 1'b1;
      i_ready = 1'b0;
      for (int i = 1; i <= 5; i++) wr(W'(i));
      tick();
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("rst_r_en", {31'h0, o_fifo_r_en}, 32'h0);
         chk("rst_valid", {31'h0, o_valid}, 32'h0);
         chk("rst_idle", {31'h0, o_idle}, 32'h1);
         chk("rst_data", {24'h0, o_data}, 32'h0);
         tick();
      end

      // Latency and full-rate stream
      reset_n = 1'b1;
      i_ready = 1'b1;
      sample();
      chk("lat_r_en_N", {31'h0, o_fifo_r_en}, 32'h1);
      chk("lat_valid_N", {31'h0, o_valid}, 32'h0);
      tick();
      sample();
      chk("lat_valid_N1", {31'h0, o_valid}, 32'h0);
      tick();
      for (int i = 1; i <= 5; i++) begin
         sample();
         chk("stream_valid", {31'h0, o_valid}, 32'h1);
         chk("stream_data", {24'h0, o_data}, 32'(i));
         tick();
      end
      sample();
      chk("stream_end_valid", {31'h0, o_valid}, 32'h0);
      chk("stream_end_idle", {31'h0, o_idle}, 32'h1);
      tick();

      // Backpressure
      i_ready = 1'b0;
      for (int i = 0; i < 8; i++) wr(8'h10 + W'(i));
      r0 = reads;
      for (int i = 0; i < 10; i++) begin
         sample();
         if (i >= 2) begin
            chk("bp_valid", {31'h0, o_valid}, 32'h1);
            chk("bp_data", {24'h0, o_data}, 32'h10);
         end
         tick();
      end
      chk("bp_reads", 32'(reads - r0), 32'd2);
      i_ready = 1'b1;
      drain(50);
      chk("bp_all_out", 32'(exp_q.size()), 32'd0);

      // i_en dropped with one word in flight
      i_ready = 1'b0;
      i_en    = 1'b1;
      wr(8'h20);
      wr(8'h21);
      r0 = reads;
      sample();
      chk("en_r_en", {31'h0, o_fifo_r_en}, 32'h1);
      tick();
      i_en = 1'b0;
      sample();
      chk("en_off_r_en", {31'h0, o_fifo_r_en}, 32'h0);
      chk("en_off_idle", {31'h0, o_idle}, 32'h0);
      tick();
      sample();
      chk("en_off_valid", {31'h0, o_valid}, 32'h1);
      chk("en_off_data", {24'h0, o_data}, 32'h20);
      tick();
      repeat (4) cyc();
      chk("en_off_reads", 32'(reads - r0), 32'd1);
      i_ready = 1'b1;
      cyc();
      sample();
      chk("en_off_drained", {31'h0, o_idle}, 32'h1);
      tick();
      i_en = 1'b1;
      drain(20);

      // Reset with the buffer full
      i_ready = 1'b0;
      for (int i = 0; i < 4; i++) wr(8'h30 + W'(i));
      repeat (4) cyc();
      sample();
      chk("two_valid", {31'h0, o_valid}, 32'h1);
      chk("two_data", {24'h0, o_data}, 32'h30);
      tick();
      reset_n = 1'b0;
      sample();
      chk("rst_mid_r_en", {31'h0, o_fifo_r_en}, 32'h0);
      tick();
      reset_n = 1'b1;
      i_ready = 1'b1;
      discard_after_reset();
      sample();
      chk("rst_mid_valid", {31'h0, o_valid}, 32'h0);
      chk("rst_mid_idle", {31'h0, o_idle}, 32'h1);
      tick();
      cyc();
      sample();
      chk("rst_next_valid", {31'h0, o_valid}, 32'h1);
      chk("rst_next_data", {24'h0, o_data}, 32'h32);
      tick();
      drain(20);

      // Random writes and random backpressure
      wc     = 0;
      cycles = 0;
      while (wc < 1000 && cycles < 5000) begin
         if ($urandom_range(0, 1) == 1) begin
            wr(W'($urandom));
            wc++;
         end
         i_ready = 1'($urandom_range(0, 1));
         cyc();
         cycles++;
      end
      chk("rand_words_written", 32'(wc), 32'd1000);
      i_ready = 1'b1;
      drain(200);
      chk("rand_all_out", 32'(exp_q.size()), 32'd0);

`ifdef FIFO_READER_STATS_EN
      // Word counter
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
      discard_after_reset();
      for (int i = 0; i < 7; i++) wr(8'h40 + W'(i));
      drain(30);
      sample();
      chk("stats_count", o_word_count, 32'd7);
      tick();
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
      sample();
      chk("stats_cleared", o_word_count, 32'd0);
      tick();
`endif

      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("no_read_when_empty", 32'(viol), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
      $finish;
   end

endmodule
